// File: rtl/if_id_stall_ctrl_pkg.sv
// rtl/if_id_stall_ctrl_pkg.sv - shared constants for the IF/ID stall and redirect control slice
package if_id_stall_ctrl_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

    // sll $0,$0,0 encodes as all zeros; used when a flush squashes IF/ID
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Decoded control bundle carried from ID into EX
    localparam int CTRL_WIDTH     = 10;
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_BRANCH    = 4;
    localparam int CTRL_ALU_SRC   = 5;
    localparam int CTRL_REG_DST   = 6;
    localparam int CTRL_ALU_OP_LO = 7;
    localparam int CTRL_ALU_OP_HI = 9;

endpackage

// File: rtl/if_id_stall_ctrl_sat_counter.sv
// rtl/if_id_stall_ctrl_sat_counter.sv - saturating up-counter cleared by synchronous reset
module if_id_stall_ctrl_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/if_id_stall_ctrl.sv
// rtl/if_id_stall_ctrl.sv - PC, IF/ID and ID/EX bubble registers driven by the hazard unit
module if_id_stall_ctrl
    import if_id_stall_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          CTRL_W   = CTRL_WIDTH,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              pc_write,
    input  logic              IF_ID_write,
    input  logic              stall,
    input  logic              take_branch,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       instr_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic [31:0]       pc,
    output logic [31:0]       IF_ID_instr,
    output logic [31:0]       IF_ID_pc_plus4,
    output logic [CTRL_W-1:0] ID_EX_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              proto_err
);

    logic [31:0] pc_plus4;
    logic        flush;
    logic        bad_combo;

    // One adder feeds both the sequential PC and the IF/ID pc+4 field
    assign pc_plus4 = pc + 32'd4;

    // A flush only happens when IF/ID is allowed to move; a held IF/ID defers the branch
    assign flush = IF_ID_write && take_branch;

    // The hazard unit should move PC and IF/ID together and stall exactly when both freeze
    assign bad_combo = (pc_write != IF_ID_write) || (stall == pc_write);

    // PC: hold, redirect, or sequential fetch
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc <= PC_RESET;
        end else if (pc_write) begin
            pc <= take_branch ? branch_target : pc_plus4;
        end
    end

    // IF/ID: hold, squash to nop on redirect, or capture the fetched instruction
    always_ff @(posedge clk) begin
        if (!rstn) begin
            IF_ID_instr    <= NOP_INSTR;
            IF_ID_pc_plus4 <= 32'd0;
        end else if (IF_ID_write) begin
            if (take_branch) begin
                IF_ID_instr    <= NOP_INSTR;
                IF_ID_pc_plus4 <= 32'd0;
            end else begin
                IF_ID_instr    <= instr_in;
                IF_ID_pc_plus4 <= pc_plus4;
            end
        end
    end

    // ID/EX control: zero bundle is the bubble; a taken branch itself still advances
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ID_EX_ctrl <= '0;
        end else begin
            ID_EX_ctrl <= stall ? '0 : ctrl_in;
        end
    end

    // Sticky flag for inconsistent hazard inputs; informational only
    always_ff @(posedge clk) begin
        if (!rstn) begin
            proto_err <= 1'b0;
        end else if (bad_combo) begin
            proto_err <= 1'b1;
        end
    end

    if_id_stall_ctrl_sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (stall),
        .count (stall_cnt)
    );

    if_id_stall_ctrl_sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule
